serial_sum_collector: RTL

//  Downstream stage of the bit-serial N-bit adder. The adder emits one sum bit per clock, LSB first.

---
 rtl/serial_sum_collector_if.sv | 21 ++
 rtl/serial_sum_collector.sv | 57 +++++
 2 files changed

// File: rtl/serial_sum_collector_if.sv
// serial_sum_collector_if: serial bit input, word valid/ready output and status of the sum collector
interface serial_sum_collector_if #(
    parameter int N = 32
);
    logic         start;
    logic         bit_in;
    logic         word_ready;
    logic         clr_ovr;
    logic [N-1:0] word_out;
    logic         word_valid;
    logic         busy;
    logic         overrun;
    modport master (
        output start, bit_in, word_ready, clr_ovr,
        input  word_out, word_valid, busy, overrun
    );
    modport slave (
        input  start, bit_in, word_ready, clr_ovr,
        output word_out, word_valid, busy, overrun
    );
endinterface

// File: rtl/serial_sum_collector.sv
// serial_sum_collector: gathers N LSB-first serial sum bits into a word held in a valid/ready register,
// flagging (sticky) any unconsumed word that gets overwritten.
module serial_sum_collector #(
    parameter int N = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    serial_sum_collector_if.slave s
);
    localparam int CW = $clog2(N);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sr_q, sr_d, word_q, word_d;
    logic          valid_q, valid_d, ovr_q, ovr_d, done;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    // start behaves the same in both states: it (re)opens a frame with this bit as bit 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done    = 1'b0;
        if (s.start) begin
            sr_d    = {s.bit_in, sr_q[N-1:1]};
            cnt_d   = CW'(1);
            state_d = COLLECT;
        end else if (state_q == COLLECT) begin
            sr_d    = {s.bit_in, sr_q[N-1:1]};
            done    = (cnt_q == CW'(N - 1));
            cnt_d   = done ? '0 : cnt_q + CW'(1);
            state_d = done ? IDLE : COLLECT;
        end
        word_d  = done ? sr_d : word_q;
        valid_d = done | (valid_q & ~s.word_ready);
        ovr_d   = (done & valid_q & ~s.word_ready) | (ovr_q & ~s.clr_ovr);
    end
    assign s.word_out   = word_q;
    assign s.word_valid = valid_q;
    assign s.busy       = (state_q == COLLECT);
    assign s.overrun    = ovr_q;
endmodule
